// File: rtl/flex_out_serializer.sv
// flex_out_serializer: shifts the output-bank vector MSB-first into a
// 595-style chain (data, shift clock, storage latch) on change or request.
module flex_out_serializer #(
  parameter int nr_bits = 16,
  parameter int clk_div = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [nr_bits-1:0] bits,
  input  logic               force_update,
  output logic               ser_data,
  output logic               ser_clk,
  output logic               ser_latch,
  output logic               busy,
  output logic               update_done
);

  localparam int DW = $clog2(clk_div + 1);
  localparam int BW = $clog2(nr_bits + 1);
  localparam logic [DW-1:0] DIV_LD = DW'(clk_div - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(nr_bits - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GUARD
  } state_t;

  state_t             r_state;
  logic [DW-1:0]      r_div;
  logic [BW-1:0]      r_cnt;
  logic [nr_bits-1:0] r_shadow;
  logic [nr_bits-1:0] r_shift;
  logic               r_pending;
  logic               r_data;
  logic               r_clk;
  logic               r_latch;
  logic               r_busy;
  logic               r_done;

  logic [nr_bits-1:0] w_next_shift;
  logic               w_div_end;

  assign w_next_shift = r_shift << 1;
  assign w_div_end    = (r_div == '0);

  assign ser_data    = r_data;
  assign ser_clk     = r_clk;
  assign ser_latch   = r_latch;
  assign busy        = r_busy;
  assign update_done = r_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_shift   <= '0;
      r_pending <= 1'b1;
      r_data    <= 1'b0;
      r_clk     <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // capture in IDLE below overrides this re-arm
      if (bits != r_shadow || force_update)
        r_pending <= 1'b1;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_clk   <= 1'b0;
          r_latch <= 1'b0;
          if (r_pending) begin
            r_shift   <= bits;
            r_shadow  <= bits;
            r_pending <= 1'b0;
            r_data    <= bits[nr_bits-1];
            r_cnt     <= '0;
            r_div     <= DIV_LD;
            r_busy    <= 1'b1;
            r_state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (w_div_end) begin
            r_div   <= DIV_LD;
            r_clk   <= 1'b1;
            r_state <= SHIFT_HI;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        SHIFT_HI: begin
          if (w_div_end) begin
            r_div <= DIV_LD;
            r_clk <= 1'b0;
            if (r_cnt == BIT_LAST) begin
              r_latch <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_shift <= w_next_shift;
              r_data  <= w_next_shift[nr_bits-1];
              r_cnt   <= r_cnt + 1'b1;
              r_state <= SHIFT_LO;
            end
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        LATCH: begin
          if (w_div_end) begin
            r_div   <= DIV_LD;
            r_latch <= 1'b0;
            r_done  <= (clk_div == 1);
            r_state <= GUARD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        GUARD: begin
          if (w_div_end) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_div  <= r_div - 1'b1;
            r_done <= (r_div == DW'(1));
          end
        end
        default: begin
          r_clk   <= 1'b0;
          r_latch <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flex_out_serializer.sv
// Bench for flex_out_serializer: frame-offset model, a 595 chain model
// and directed scenarios on a clk_div=2 and a clk_div=1 instance.
module tb_flex_out_serializer;

  localparam int NB = 16;

  logic clk;
  logic rst_a, rst_b;
  logic [NB-1:0] bits_a, bits_b;
  logic force_a, force_b;
  logic sd_a, sc_a, sl_a, bz_a, ud_a;
  logic sd_b, sc_b, sl_b, bz_b, ud_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  flex_out_serializer #(.nr_bits(NB), .clk_div(2)) dut_a (
    .clock(clk), .reset(rst_a), .bits(bits_a),
    .force_update(force_a), .ser_data(sd_a), .ser_clk(sc_a),
    .ser_latch(sl_a), .busy(bz_a), .update_done(ud_a)
  );

  flex_out_serializer #(.nr_bits(NB), .clk_div(1)) dut_b (
    .clock(clk), .reset(rst_b), .bits(bits_b),
    .force_update(force_b), .ser_data(sd_b), .ser_clk(sc_b),
    .ser_latch(sl_b), .busy(bz_b), .update_done(ud_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: a frame is a timeline indexed by offset from capture
  int m_cd[2];
  logic m_act[2];
  int m_o[2];
  logic [NB-1:0] m_data[2];
  logic [NB-1:0] m_shadow[2];
  logic m_pend[2];
  logic m_held[2];

  task automatic m_reset(int i);
    m_act[i] = 1'b0;
    m_o[i] = 0;
    m_data[i] = '0;
    m_shadow[i] = '0;
    m_pend[i] = 1'b1;
    m_held[i] = 1'b0;
  endtask

  task automatic m_step(int i, logic [NB-1:0] b, logic f);
    int len;
    len = 2 * m_cd[i] * NB + 2 * m_cd[i];
    if (!m_act[i] && m_pend[i]) begin
      m_data[i] = b;
      m_shadow[i] = b;
      m_pend[i] = 1'b0;
      m_act[i] = 1'b1;
      m_o[i] = 0;
    end else begin
      if (b != m_shadow[i] || f) m_pend[i] = 1'b1;
      if (m_act[i]) begin
        m_o[i]++;
        if (m_o[i] == len) begin
          m_act[i] = 1'b0;
          m_held[i] = m_data[i][0];
        end
      end
    end
  endtask

  // {data, clk, latch, busy, done}
  function automatic logic [4:0] m_out(int i);
    int cd, o, sl, k;
    logic hi;
    cd = m_cd[i];
    o = m_o[i];
    sl = 2 * cd * NB;
    if (!m_act[i]) return {m_held[i], 4'b0000};
    if (o < sl) begin
      k = o / (2 * cd);
      hi = (o % (2 * cd)) >= cd;
      return {m_data[i][NB-1-k], hi, 1'b0, 1'b1, 1'b0};
    end
    if (o < sl + cd) return {m_data[i][0], 1'b0, 1'b1, 1'b1, 1'b0};
    return {m_data[i][0], 1'b0, 1'b0, 1'b1, o == sl + 2 * cd - 1};
  endfunction

  initial begin
    m_cd[0] = 2;
    m_reset(0);
    forever begin
      @(posedge clk or negedge rst_a);
      if (!rst_a) m_reset(0);
      else m_step(0, bits_a, force_a);
    end
  end

  initial begin
    m_cd[1] = 1;
    m_reset(1);
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) m_reset(1);
      else m_step(1, bits_b, force_b);
    end
  end

  // chain model: shift on rising ser_clk, store on rising latch
  logic [NB-1:0] ch_a = '0, ch_b = '0;
  logic [NB-1:0] lat_a[$];
  logic [NB-1:0] lat_b[$];
  int edges_a = 0, edges_b = 0;
  int bcnt_a = 0, bcnt_b = 0, dcnt_a = 0;

  initial forever begin
    @(posedge sc_a);
    ch_a = {ch_a[NB-2:0], sd_a};
    edges_a++;
  end
  initial forever begin
    @(posedge sc_b);
    ch_b = {ch_b[NB-2:0], sd_b};
    edges_b++;
  end
  initial forever begin
    @(posedge sl_a);
    lat_a.push_back(ch_a);
  end
  initial forever begin
    @(posedge sl_b);
    lat_b.push_back(ch_b);
  end

  task automatic cmp(int i, logic [4:0] got);
    logic [4:0] exp;
    exp = m_out(i);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_%0d inst%0d {data,clk,latch,busy,done} got=%b exp=%b",
               cyc, i, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    cmp(0, {sd_a, sc_a, sl_a, bz_a, ud_a});
    cmp(1, {sd_b, sc_b, sl_b, bz_b, ud_b});
    if (bz_a) bcnt_a++;
    if (bz_b) bcnt_b++;
    if (ud_a) dcnt_a++;
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_done(int i, int maxc);
    bit got;
    got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      @(negedge clk);
      got = (i == 0) ? ud_a : ud_b;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_done inst%0d got=timeout exp=pulse", i);
    end
    @(negedge clk);
  endtask

  task automatic wait_edges(int n, int maxc);
    for (int c = 0; c < maxc && edges_a < n; c++) @(negedge clk);
    chk("wait_edges", edges_a, n);
  endtask

  function automatic logic [NB-1:0] qa(int idx);
    if (lat_a.size() > idx) return lat_a[idx];
    return 'x;
  endfunction

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bits_a = 16'hA5C3;
    bits_b = 16'hFFFF;
    force_a = 1'b0;
    force_b = 1'b0;
    #12;
    chk("reset_outs_a", {sd_a, sc_a, sl_a, bz_a, ud_a}, 5'b0);

    // 1: first frame after release
    @(negedge clk);
    rst_a = 1'b1;
    edges_a = 0; bcnt_a = 0; dcnt_a = 0;
    wait_done(0, 300);
    chk("t1_edges", edges_a, 16);
    chk("t1_word", qa(0), 16'hA5C3);
    chk("t1_busy_cycles", bcnt_a, 68);
    chk("t1_done_pulses", dcnt_a, 1);

    // 2: quiet bus when nothing changes
    edges_a = 0; bcnt_a = 0;
    repeat (500) @(negedge clk);
    chk("t2_edges", edges_a, 0);
    chk("t2_busy", bcnt_a, 0);

    // 3: changes during a frame coalesce into one follow-up frame
    bits_a = 16'h5A5A;
    edges_a = 0;
    wait_edges(5, 200);
    @(negedge clk);
    bits_a = 16'h0001;
    repeat (2) @(negedge clk);
    bits_a = 16'h0002;
    wait_done(0, 300);
    wait_done(0, 300);
    edges_a = 0;
    repeat (200) @(negedge clk);
    chk("t3_no_third_frame", edges_a, 0);
    chk("t3_frames", lat_a.size(), 3);
    chk("t3_word_inflight", qa(1), 16'h5A5A);
    chk("t3_word_next", qa(2), 16'h0002);

    // 4: forced resend of an unchanged value
    force_a = 1'b1;
    @(negedge clk);
    force_a = 1'b0;
    wait_done(0, 300);
    repeat (50) @(negedge clk);
    chk("t4_frames", lat_a.size(), 4);
    chk("t4_word", qa(3), 16'h0002);

    // 5: asynchronous reset mid-frame
    bits_a = 16'h00FF;
    edges_a = 0;
    wait_edges(8, 200);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1 chk("t5_async_outs", {sd_a, sc_a, sl_a, bz_a, ud_a}, 5'b0);
    bits_a = 16'h1234;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    wait_done(0, 300);
    chk("t5_frames", lat_a.size(), 5);
    chk("t5_word", qa(4), 16'h1234);

    // 6: clk_div=1 instance
    @(negedge clk);
    rst_b = 1'b1;
    edges_b = 0; bcnt_b = 0;
    wait_done(1, 200);
    chk("t6_busy_cycles", bcnt_b, 34);
    chk("t6_edges", edges_b, 16);
    chk("t6_frames", lat_b.size(), 1);
    chk("t6_word", (lat_b.size() > 0) ? lat_b[0] : 'x, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
